// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler owning the select of a shared 16:1 bit mux.
// Picks a pending requester, captures its data bit, and hands it off over valid/ready.
module mux_rr_scheduler #(
   parameter int N  = 16,
   parameter int SW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  data,
   input  logic          out_ready,
   output logic [SW-1:0] sel,
   output logic          out_valid,
   output logic          out_data,
   output logic [N-1:0]  gnt,
   output logic          busy
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] VALID = 1'b1;

   logic [0:0]    state;
   logic [SW-1:0] ptr;
   logic [N-1:0]  sel_oh;
   logic          xfer;
   logic [SW-1:0] start;
   logic [N-1:0]  cand;
   logic [SW-1:0] win;
   logic [SW-1:0] idx;
   logic          found;

   assign out_valid = (state == VALID);
   assign busy      = out_valid;
   assign sel_oh    = N'(1) << sel;
   assign xfer      = out_valid & out_ready;
   assign gnt       = xfer ? sel_oh : '0;

   // On a handshake the winner is masked and the search starts just past it.
   always_comb begin
      start = out_valid ? sel + SW'(1) : ptr;
      cand  = out_valid ? (req & ~sel_oh) : req;
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = start + SW'(k);
         if (!found && cand[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         sel      <= '0;
         out_data <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  sel      <= win;
                  out_data <= data[win];
                  state    <= VALID;
               end
            end
            VALID: begin
               if (out_ready) begin
                  ptr <= sel + SW'(1);
                  if (found) begin
                     sel      <= win;
                     out_data <= data[win];
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed self-checking bench for mux_rr_scheduler.
// Hand-computed expectations for arbitration order, hold, wrap and reset.
module tb_mux_rr_scheduler;

   logic        clk;
   logic        rst;
   logic [15:0] req;
   logic [15:0] data;
   logic        out_ready;
   logic [3:0]  sel;
   logic        out_valid;
   logic        out_data;
   logic [15:0] gnt;
   logic        busy;

   int checks;
   int failures;

   mux_rr_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data      (data),
      .out_ready (out_ready),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .gnt       (gnt),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] rrdata;
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      req       = '0;
      data      = '0;
      out_ready = 1'b0;
      #1;
      chk("rst_valid", 16'(out_valid), 16'd0);
      chk("rst_sel",   16'(sel),       16'd0);
      chk("rst_data",  16'(out_data),  16'd0);
      chk("rst_gnt",   gnt,            16'h0000);
      chk("rst_busy",  16'(busy),      16'd0);
      step();
      rst = 1'b0;
      step();
      step();
      chk("idle_valid", 16'(out_valid), 16'd0);

      // single request
      req  = 16'h0020;
      data = 16'h674F;
      step();
      chk("single_sel",   16'(sel),       16'd5);
      chk("single_data",  16'(out_data),  16'd0);
      chk("single_valid", 16'(out_valid), 16'd1);
      chk("single_busy",  16'(busy),      16'd1);
      chk("single_nogt",  gnt,            16'h0000);
      out_ready = 1'b1;
      #1;
      chk("single_gnt", gnt, 16'h0020);
      req = 16'h0000;
      step();
      chk("single_idle", 16'(out_valid), 16'd0);
      chk("single_gnt0", gnt,            16'h0000);
      // pointer now 6
      req = 16'hFFFF;
      step();
      chk("ptr6_sel", 16'(sel), 16'd6);
      req = 16'h0000;
      step();
      chk("ptr6_idle", 16'(out_valid), 16'd0);

      // backpressure
      out_ready = 1'b0;
      req  = 16'h1000;
      data = 16'h1000;
      step();
      for (int i = 0; i < 4; i++) begin
         data = ~data;
         req  = 16'h1001;
         #1;
         chk("bp_sel",  16'(sel),      16'd12);
         chk("bp_data", 16'(out_data), 16'd1);
         chk("bp_gnt",  gnt,           16'h0000);
         step();
      end
      req = 16'h1000;
      out_ready = 1'b1;
      #1;
      chk("bp_gnt12", gnt, 16'h1000);
      req = 16'h0000;
      step();
      chk("bp_idle", 16'(out_valid), 16'd0);
      chk("bp_gnt0", gnt,            16'h0000);

      // wrap and masking: grant 13 then pointer sits at 14
      req  = 16'h2000;
      data = 16'h0008;
      step();
      chk("wrap_sel13", 16'(sel), 16'd13);
      req = 16'h8009;
      #1;
      chk("wrap_gnt13", gnt, 16'h2000);
      step();
      chk("wrap_sel15",  16'(sel),      16'd15);
      chk("wrap_dat15",  16'(out_data), 16'd0);
      chk("wrap_gnt15",  gnt,           16'h8000);
      step();
      chk("wrap_sel0",   16'(sel),      16'd0);
      chk("wrap_dat0",   16'(out_data), 16'd0);
      chk("wrap_gnt0",   gnt,           16'h0001);
      step();
      chk("wrap_sel3",   16'(sel),      16'd3);
      chk("wrap_dat3",   16'(out_data), 16'd1);
      chk("wrap_gnt3",   gnt,           16'h0008);
      req = 16'h0000;
      step();
      chk("wrap_idle",   16'(out_valid), 16'd0);

      // reset mid-transfer
      out_ready = 1'b0;
      req = 16'h0080;
      step();
      chk("mrst_sel7", 16'(sel), 16'd7);
      out_ready = 1'b1;
      #1;
      chk("mrst_gnt7", gnt, 16'h0080);
      rst = 1'b1;
      #1;
      chk("mrst_valid", 16'(out_valid), 16'd0);
      chk("mrst_sel",   16'(sel),       16'd0);
      chk("mrst_gnt",   gnt,            16'h0000);
      req = 16'h0000;
      step();
      rst = 1'b0;
      step();
      step();
      chk("mrst_idle", 16'(out_valid), 16'd0);

      // late arrival
      out_ready = 1'b0;
      req  = 16'h0018;
      data = 16'h0000;
      step();
      chk("late_sel3", 16'(sel), 16'd3);
      req = 16'h001C;
      step();
      chk("late_hold3", 16'(sel), 16'd3);
      out_ready = 1'b1;
      #1;
      chk("late_gnt3", gnt, 16'h0008);
      step();
      chk("late_sel4", 16'(sel), 16'd4);
      chk("late_gnt4", gnt,      16'h0010);
      req = 16'h0014;
      step();
      chk("late_sel2", 16'(sel), 16'd2);
      chk("late_gnt2", gnt,      16'h0004);
      req = 16'h0000;
      step();
      chk("late_idle", 16'(out_valid), 16'd0);

      // full round-robin from pointer 0
      rst = 1'b1;
      #1;
      step();
      rst    = 1'b0;
      rrdata = 16'hA017;
      data   = rrdata;
      req    = 16'hFFFF;
      step();
      for (int i = 0; i < 17; i++) begin
         chk("rr_sel",  16'(sel),        16'(i % 16));
         chk("rr_data", 16'(out_data),   16'(rrdata[i % 16]));
         chk("rr_gnt",  gnt,             16'(16'h0001 << (i % 16)));
         if (i == 16) req = 16'h0000;
         step();
      end
      chk("rr_idle", 16'(out_valid), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
